// File: rtl/note_player_pkg.sv
// note_player_pkg: shared state encoding and constants for note_player
package note_player_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
  localparam int MIN_PERIOD = 2;
endpackage

// File: rtl/note_player.sv
// note_player: plays one PWM note of dur wave periods, pacing itself off an external wrap counter
module note_player
  import note_player_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DUR_WIDTH = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 note_valid_in,
  output logic                 note_ready_out,
  input  logic [WIDTH-1:0]     note_period_in,
  input  logic [WIDTH-1:0]     note_duty_in,
  input  logic [DUR_WIDTH-1:0] note_dur_in,
  input  logic                 stop_in,
  input  logic [WIDTH-1:0]     count_in,
  output logic [WIDTH-1:0]     period_out,
  output logic                 cnt_rst_out,
  output logic                 wave_out,
  output logic                 busy_out,
  output logic                 done_out
);
  state_t               state, state_d;
  logic [WIDTH-1:0]     period_q, period_d, duty_q, duty_d;
  logic [DUR_WIDTH-1:0] rem_q, rem_d;
  logic                 cnt_rst_d, wave_d, done_d, hs, wrap, zero_dur;
  assign note_ready_out = state == IDLE && !stop_in;
  assign hs             = note_valid_in && note_ready_out;
  assign zero_dur       = note_dur_in == '0;
  assign wrap           = state == PLAY && count_in == period_q - WIDTH'(1);
  assign busy_out       = state != IDLE;
  assign period_out     = period_q;
  // stop_in wins over everything; a zero-length note completes straight from IDLE
  always_comb begin
    state_d   = state;
    period_d  = period_q;
    duty_d    = duty_q;
    rem_d     = rem_q;
    cnt_rst_d = 1'b0;
    done_d    = 1'b0;
    wave_d    = state == PLAY && count_in < duty_q && !stop_in;
    if (stop_in) begin
      state_d = IDLE;
    end else if (hs) begin
      period_d  = note_period_in < WIDTH'(MIN_PERIOD) ? WIDTH'(MIN_PERIOD) : note_period_in;
      duty_d    = note_duty_in;
      rem_d     = note_dur_in;
      state_d   = zero_dur ? IDLE : LOAD;
      cnt_rst_d = !zero_dur;
      done_d    = zero_dur;
    end else if (state == LOAD) begin
      state_d = PLAY;
    end else if (wrap) begin
      rem_d   = rem_q == '0 ? '0 : rem_q - DUR_WIDTH'(1);
      state_d = rem_q <= DUR_WIDTH'(1) ? IDLE : PLAY;
      done_d  = rem_q <= DUR_WIDTH'(1);
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      period_q    <= '0;
      duty_q      <= '0;
      rem_q       <= '0;
      cnt_rst_out <= 1'b0;
      wave_out    <= 1'b0;
      done_out    <= 1'b0;
    end else begin
      state       <= state_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      rem_q       <= rem_d;
      cnt_rst_out <= cnt_rst_d;
      wave_out    <= wave_d;
      done_out    <= done_d;
    end
  end
endmodule

// File: tb/tb_note_player.sv
// tb_note_player: directed notes with a per-cycle expectation scoreboard and an external wrap counter
module tb_note_player;
  logic        clk_in = 1'b0;
  logic        rst_n_in, note_valid_in, note_ready_out, stop_in;
  logic [31:0] note_period_in, note_duty_in, count_in, period_out;
  logic [15:0] note_dur_in;
  logic        cnt_rst_out, wave_out, busy_out, done_out;
  typedef struct packed {
    logic        w, d, c, b, r;
    logic [31:0] p;
  } exp_t;
  exp_t        q[$];
  int          checks = 0, errors = 0;
  logic [31:0] last_per = 0;

  always #5 clk_in = ~clk_in;

  note_player #(.WIDTH(32), .DUR_WIDTH(16)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .note_valid_in(note_valid_in),
    .note_ready_out(note_ready_out), .note_period_in(note_period_in),
    .note_duty_in(note_duty_in), .note_dur_in(note_dur_in), .stop_in(stop_in),
    .count_in(count_in), .period_out(period_out), .cnt_rst_out(cnt_rst_out),
    .wave_out(wave_out), .busy_out(busy_out), .done_out(done_out)
  );

  // external wrap counter driven by the DUT's period/restart outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) count_in <= '0;
    else if (cnt_rst_out) count_in <= '0;
    else count_in <= count_in >= period_out - 32'd1 ? 32'd0 : count_in + 32'd1;
  end

  always @(negedge clk_in) begin
    if (q.size() > 0) begin
      exp_t e, a;
      e = q.pop_front();
      a = {wave_out, done_out, cnt_rst_out, busy_out, note_ready_out, period_out};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got wave=%b done=%b crst=%b busy=%b ready=%b per=%0d exp wave=%b done=%b crst=%b busy=%b ready=%b per=%0d",
                 $time, a.w, a.d, a.c, a.b, a.r, a.p, e.w, e.d, e.c, e.b, e.r, e.p);
      end
    end
  end

  task automatic step(input logic w, d, c, b, r, input logic [31:0] p);
    q.push_back({w, d, c, b, r, p});
    @(posedge clk_in);
    #1;
  endtask

  task automatic note(input logic [31:0] per, duty, input logic [15:0] dur,
                      input logic [31:0] ep, input string wv);
    note_period_in = per;
    note_duty_in   = duty;
    note_dur_in    = dur;
    note_valid_in  = 1'b1;
    step(0, 0, 0, 0, 1, last_per);
    note_valid_in = 1'b0;
    if (dur == 0) begin
      step(0, 1, 0, 0, 1, ep);
    end else begin
      step(0, 0, 1, 1, 0, ep);
      step(0, 0, 0, 1, 0, ep);
      for (int i = 0; i < wv.len(); i++) begin
        logic last;
        last = i == wv.len() - 1;
        step(wv[i] == 8'h31, last, 0, !last, last, ep);
      end
    end
    last_per = ep;
    step(0, 0, 0, 0, 1, ep);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n_in = 1'b0; note_valid_in = 1'b0; stop_in = 1'b0;
    note_period_in = '0; note_duty_in = '0; note_dur_in = '0;
    @(posedge clk_in);
    #1;
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    rst_n_in = 1'b1;
    step(0, 0, 0, 0, 1, 0);
    note(4, 2, 3, 4, "110011001100");
    note(5, 9, 2, 5, "1111111111");
    note(0, 1, 2, 2, "1010");
    note(3, 1, 2, 3, "100100");
    note(3, 0, 1, 3, "000");
    note(3, 1, 0, 3, "");
    // stop during PLAY of a long note
    note_period_in = 4; note_duty_in = 2; note_dur_in = 10; note_valid_in = 1'b1;
    step(0, 0, 0, 0, 1, last_per);
    note_valid_in = 1'b0;
    last_per = 4;
    step(0, 0, 1, 1, 0, 4);
    step(0, 0, 0, 1, 0, 4);
    step(1, 0, 0, 1, 0, 4);
    step(1, 0, 0, 1, 0, 4);
    step(0, 0, 0, 1, 0, 4);
    step(0, 0, 0, 1, 0, 4);
    stop_in = 1'b1;
    step(1, 0, 0, 1, 0, 4);
    note_valid_in = 1'b1;
    step(0, 0, 0, 0, 0, 4);
    stop_in = 1'b0; note_valid_in = 1'b0;
    step(0, 0, 0, 0, 1, 4);
    step(0, 0, 0, 0, 1, 4);
    // asynchronous reset in the middle of PLAY
    note_period_in = 4; note_duty_in = 2; note_dur_in = 3; note_valid_in = 1'b1;
    step(0, 0, 0, 0, 1, 4);
    note_valid_in = 1'b0;
    step(0, 0, 1, 1, 0, 4);
    step(0, 0, 0, 1, 0, 4);
    step(1, 0, 0, 1, 0, 4);
    step(1, 0, 0, 1, 0, 4);
    q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0});
    #2 rst_n_in = 1'b0;
    #4 rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    last_per = 0;
    note(4, 2, 3, 4, "110011001100");
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 SHALL have parameter: WIDTH, 32, width of period/duty/count buses.
REQ-002 SHALL have parameter: DUR_WIDTH, 16, width of the note-duration field (in wave periods).
REQ-003 SHALL have port: clk_in  input  1  single system clock; all logic on posedge.
REQ-004 SHALL have port: rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port: note_valid_in  input  1  note command valid.
REQ-006 SHALL have port: note_ready_out  output  1  note command ready.
REQ-007 SHALL have port: note_period_in  input  WIDTH  wave period in clk cycles.
REQ-008 SHALL have port: note_duty_in  input  WIDTH  high cycles per period.
REQ-009 SHALL have port: note_dur_in  input  DUR_WIDTH  number of wave periods to play.
REQ-010 SHALL have port: stop_in  input  1  abort current note.
REQ-011 SHALL have port: count_in  input  WIDTH  count from the external wrap counter.
REQ-012 SHALL have port: period_out  output  WIDTH  period driven to that counter's period input.
REQ-013 SHALL have port: cnt_rst_out  output  1  synchronous restart pulse to that counter.
REQ-014 SHALL have port: wave_out  output  1  PWM/square audio output.
REQ-015 SHALL have port: busy_out  output  1  high whenever state != IDLE.
REQ-016 SHALL have port: done_out  output  1  one-cycle pulse on normal note completion.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD and PLAY.
REQ-018 SHALL drive note_ready_out combinationally as (state==IDLE && !stop_in); a handshake is valid && ready at a clock edge.
REQ-019 On a handshake at edge T, SHALL capture period, duty and duration, and coerce a period < 2 to 2.
REQ-020 On a handshake with note_dur_in==0, SHALL stay in IDLE and pulse done_out in cycle T+1, with no LOAD and wave_out low.
REQ-021 On any other handshake, SHALL enter LOAD in cycle T+1, with cnt_rst_out=1 (registered, one cycle only) and period_out updated to the captured period.
REQ-022 LOAD SHALL always go to PLAY on the next edge; the counter therefore presents count_in=0 in the first PLAY cycle (T+2).
REQ-023 In PLAY, a wrap SHALL be count_in == period_q-1, and each wrap SHALL decrement the remaining-periods register.
REQ-024 On a wrap with remaining==1, PLAY SHALL go to IDLE, with done_out=1 in the following cycle only.
REQ-025 SHALL register wave_out <= (state==PLAY) && (count_in < duty_q), giving one cycle of latency.
REQ-026 SHALL make wave_out constant-high across a note when duty >= period, and constant-low when duty == 0.
REQ-027 Total wave high+low time SHALL be exactly dur*period cycles, from T+3 through T+2+dur*period inclusive.
REQ-028 SHALL hold period_out at its last loaded value while in IDLE.
REQ-029 SHALL make stop_in take priority over handshake, wrap and completion: next state IDLE, wave_out 0 next cycle, no done_out.
REQ-030 SHALL use unsigned arithmetic only, and the duration counter SHALL never wrap below 0.

Reset
REQ-031 On rst_n_in low, SHALL immediately (asynchronously) force state=IDLE, period_out=0, cnt_rst_out=0, wave_out=0, done_out=0, busy_out=0, and clear all captured registers.
REQ-032 Reset asserted mid-note SHALL abandon the note with no done_out; after release, the block SHALL accept a new command in the first cycle.

Structure
REQ-033 Package note_player_pkg SHALL hold the state enum typedef and the MIN_PERIOD=2 constant.
REQ-034 SHALL have no sub-module; the wrap counter stays external and is connected via period_out, cnt_rst_out and count_in.

Verification
REQ-035 Bench SHALL check: period=4, duty=2, dur=3 handshake at T -> cnt_rst_out high at T+1 only; wave_out 1,1,0,0 repeated x3 over T+3..T+14; done_out high at T+14 only.
REQ-036 Bench SHALL check: period=5, duty=9, dur=2 -> wave_out high T+3..T+12, low from T+13; done_out at T+12.
REQ-037 Bench SHALL check: period=0, duty=1, dur=2 -> period_out=2, wave_out 1,0,1,0, done_out at T+6.
REQ-038 Bench SHALL check: dur=0 command -> done_out at T+1, state stays IDLE, cnt_rst_out never pulses, note_ready_out stays 1.
REQ-039 Bench SHALL check: stop_in during PLAY of a dur=10 note -> IDLE next edge, wave_out 0, no done_out; stop_in together with note_valid_in in IDLE -> no handshake.
REQ-040 Bench SHALL check: rst_n_in pulsed low mid-PLAY between clock edges -> outputs zero before the next edge; a new note after release behaves as in REQ-035.
